// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register with a
// one-entry skid buffer for decode stalls, and flush/refetch on redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPC_W    = 7;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] RESET_ADDR = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_KILL
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_instr;
  logic [XLEN-1:0] r_buf_instr;
  logic [XLEN-1:0] r_buf_pc;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_redirect_tgt;
  logic            w_handshake;

  assign w_redirect_tgt = redirect_pc & ALIGN_MASK;
  assign w_handshake    = r_imem_req & imem_ready;

  // Next state and next fetch pc; redirect overrides every other pc update.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          w_state_nxt = imem_ready ? S_FETCH : S_KILL;
        end else if (imem_ready) begin
          w_pc_nxt    = r_pc + XLEN'(4);
          w_state_nxt = stall ? S_HOLD : S_FETCH;
        end
      end
      S_HOLD:  if (redirect || !stall) w_state_nxt = S_FETCH;
      S_KILL:  if (imem_ready) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
    if (redirect) w_pc_nxt = w_redirect_tgt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_ADDR;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_ADDR;
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_instr  <= NOP_INSTR;
      r_buf_instr <= NOP_INSTR;
      r_buf_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_imem_req <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_KILL);
      // A killed request keeps its original address until memory answers.
      if (w_state_nxt != S_KILL) r_imem_addr <= w_pc_nxt;

      if (redirect) begin
        r_id_valid  <= 1'b0;
        r_id_instr  <= NOP_INSTR;
        r_buf_instr <= NOP_INSTR;
        r_buf_pc    <= '0;
      end else begin
        case (r_state)
          S_FETCH: begin
            if (stall) begin
              if (w_handshake) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc    <= r_pc;
              end
            end else if (w_handshake) begin
              r_id_valid <= 1'b1;
              r_id_pc    <= r_pc;
              r_id_instr <= imem_rdata;
            end else begin
              r_id_valid <= 1'b0;
              r_id_instr <= NOP_INSTR;
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_id_valid <= 1'b1;
              r_id_pc    <= r_buf_pc;
              r_id_instr <= r_buf_instr;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;
  assign id_opcode = r_id_instr[OPC_W-1:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a request/queue level model.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, imem_ready;
  logic [31:0] redirect_pc, key;

  logic        imem_req, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;
  logic [6:0]  id_opcode;

  logic        imem_req2, id_valid2;
  logic [31:0] imem_addr2, imem_rdata2, id_pc2, id_instr2;
  logic [6:0]  id_opcode2;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign imem_rdata  = imem_addr ^ key;
  assign imem_rdata2 = imem_addr2 ^ key;

  ifetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata2), .id_valid(id_valid2),
    .id_pc(id_pc2), .id_instr(id_instr2), .id_opcode(id_opcode2)
  );

  // Model: a request is in flight whenever nothing waits in the buffer queue;
  // m_drop marks an in-flight request whose data must be thrown away.
  bit          m_idle;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [63:0] q[$];
  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit          req;
    bit          hs;
    logic [63:0] item;
    if (!rst_n) begin
      m_idle = 1; m_drop = 0; m_pc = 32'h0; m_addr = 32'h0;
      q.delete();
      e_valid = 0; e_pc = 32'h0; e_instr = NOP;
      return;
    end
    req = !m_idle && (q.size() == 0);
    hs  = req && imem_ready;
    if (redirect) begin
      e_valid = 0; e_instr = NOP;
      q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      if (req && !hs) m_drop = 1;
      else begin m_drop = 0; m_addr = m_pc; end
    end else begin
      if (hs) begin
        if (!m_drop) begin
          q.push_back({m_addr, m_addr ^ key});
          m_pc = m_pc + 32'd4;
        end
        m_drop = 0;
        m_addr = m_pc;
      end
      if (!stall) begin
        if (q.size() > 0) begin
          item = q.pop_front();
          e_valid = 1; e_pc = item[63:32]; e_instr = item[31:0];
        end else begin
          e_valid = 0; e_instr = NOP;
        end
      end
    end
    m_idle = 0;
  endtask

  task automatic check_model();
    bit m_req;
    m_req = !m_idle && (q.size() == 0);
    check("req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) check("addr", imem_addr, m_addr);
    check("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
    check("id_pc", id_pc, e_pc);
    check("id_instr", id_instr, e_instr);
    check("id_opcode", {25'b0, id_opcode}, {25'b0, e_instr[6:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 32'h0; imem_ready = 1; key = 32'h0;
    tick(); tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'h13);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_req2", {31'b0, imem_req2}, 32'd0);

    rst_n = 1;
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_req2", {31'b0, imem_req2}, 32'd1);
    check("first_addr2", imem_addr2, 32'hFFFF_FFFC);
    tick();
    check("seq_id_pc0", id_pc, 32'h0);
    check("seq_valid0", {31'b0, id_valid}, 32'd1);
    check("seq_addr4", imem_addr, 32'h4);
    check("wrap_addr2", imem_addr2, 32'h0);
    check("wrap_id_pc2", id_pc2, 32'hFFFF_FFFC);
    tick();
    check("seq_id_pc4", id_pc, 32'h4);
    check("seq_addr8", imem_addr, 32'h8);

    imem_ready = 0;
    tick(); tick();
    check("wait_addr", imem_addr, 32'h8);
    check("wait_valid", {31'b0, id_valid}, 32'd0);
    check("wait_instr", id_instr, 32'h13);
    imem_ready = 1;
    tick();
    check("wait_id_pc", id_pc, 32'h8);
    check("wait_next_addr", imem_addr, 32'hC);

    stall = 1;
    tick();
    check("hold_req", {31'b0, imem_req}, 32'd0);
    check("hold_id_pc", id_pc, 32'h8);
    tick(); tick();
    check("hold_req_3", {31'b0, imem_req}, 32'd0);
    check("hold_frozen", id_pc, 32'h8);
    stall = 0;
    tick();
    check("release_id_pc", id_pc, 32'hC);
    check("release_addr", imem_addr, 32'h10);
    tick();

    imem_ready = 0; redirect = 1; redirect_pc = 32'h100;
    tick();
    check("kill_valid", {31'b0, id_valid}, 32'd0);
    check("kill_addr", imem_addr, 32'h14);
    redirect = 0; imem_ready = 1;
    tick();
    check("refetch_addr", imem_addr, 32'h100);
    check("refetch_valid", {31'b0, id_valid}, 32'd0);
    tick();
    check("refetch_id_pc", id_pc, 32'h100);

    stall = 1; redirect = 1; redirect_pc = 32'h103;
    tick();
    check("flush_wins_valid", {31'b0, id_valid}, 32'd0);
    check("flush_wins_addr", imem_addr, 32'h100);

    stall = 0; imem_ready = 0; redirect = 1; redirect_pc = 32'h200;
    tick();
    check("kill2_addr", imem_addr, 32'h100);
    redirect = 0; rst_n = 0;
    tick();
    check("rst_kill_req", {31'b0, imem_req}, 32'd0);
    check("rst_kill_addr", imem_addr, 32'h0);
    rst_n = 1;

    key = $urandom;
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 99) < 30);
      imem_ready  = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      rst_n       = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): instruction presented while id_valid=0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  hazard stall from decode; hold IF/ID and PC.
REQ-006 redirect  input  1  taken branch/JAL/JALR from execute; flush and refetch.
REQ-007 redirect_pc  input  32  target address, valid when redirect=1.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_ready  input  1  memory completes the current request this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-012 id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 id_pc  output  32  PC of the IF/ID instruction.
REQ-014 id_instr  output  32  IF/ID instruction word.
REQ-015 id_opcode  output  7  id_instr[6:0], combinational, feeds decode controller.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD, KILL; id_*, pc, one-entry buffer (buf_instr, buf_pc) and state SHALL all be registers.
REQ-017 IDLE: imem_req=0; next state FETCH unconditionally (one cycle after reset release).
REQ-018 FETCH: imem_req=1, imem_addr=pc; handshake completes on any cycle with imem_req && imem_ready.
REQ-019 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-020 FETCH, ready=1, stall=0, redirect=0: id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4, stay FETCH.
REQ-021 FETCH, ready=0, stall=0, redirect=0: id_valid<=0, id_instr<=NOP_INSTR (bubble), pc unchanged.
REQ-022 FETCH, stall=1, redirect=0: id_* held; if ready=1, capture imem_rdata/pc into buffer, pc<=pc+4, go HOLD; else stay FETCH.
REQ-023 HOLD: imem_req=0; id_* held while stall=1; when stall=0: id_instr<=buf_instr, id_pc<=buf_pc, id_valid<=1, go FETCH.
REQ-024 redirect=1 SHALL have priority over stall in every state: id_valid<=0, id_instr<=NOP_INSTR, buffer discarded, pc<={redirect_pc[31:2],2'b00}.
REQ-025 redirect in FETCH with ready=0: go KILL; request stays asserted at old address until ready.
REQ-026 redirect in FETCH with ready=1, or in HOLD/IDLE: go FETCH; returned data, if any, discarded.
REQ-027 KILL: imem_req=1 at old address; on ready, discard imem_rdata, go FETCH at redirected pc; further redirect in KILL only updates pc.
REQ-028 pc+4 SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-029 At most one outstanding request; no new address issued until the current request completes.

Reset
REQ-030 While rst_n=0 at a clock edge: state<=IDLE, pc<=RESET_PC, id_valid<=0, id_pc<=0, id_instr<=NOP_INSTR, buffer cleared.
REQ-031 During reset imem_req=0; stall, redirect, imem_ready ignored.
REQ-032 Reset asserted mid-request SHALL abandon the request; memory is reset in the same domain.

Verification
REQ-033 Reset release, imem_ready=1, rdata=addr: imem_addr 0,4,8,...; id_pc 0,4,... with id_valid=1 one edge after each handshake.
REQ-034 imem_ready low 2 cycles at addr 0x8: imem_addr holds 0x8, id_valid=0 and id_instr=0x13 for 2 cycles, then id_pc=0x8.
REQ-035 stall=1 for 3 cycles while ready=1 at 0xC: one handshake, HOLD, imem_req=0, id_* frozen; after release id_pc=0xC, next fetch 0x10.
REQ-036 redirect=1, redirect_pc=0x100 while request at 0x14 outstanding: KILL, 0x14 data dropped, id_valid=0, next imem_addr=0x100.
REQ-037 redirect_pc=0x103 with stall=1 same cycle: flush wins, id_valid=0, next imem_addr=0x100.
REQ-038 RESET_PC=0xFFFF_FFFC: first fetch 0xFFFF_FFFC, second 0x0000_0000; rst_n low mid-KILL -> imem_req=0, restart at RESET_PC.
